ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Parametrised PS/2 scan-code tracker. Replaces the fixed 4-key decode behind the keyboard top level.
//  Consumes the byte stream from KeyboardPS2_Controller (received_data / received_data_en).
//  Decodes make, break (F0), extended (E0) and Pause (E1) sequences.
//  Tracks held state for NUM_KEYS configurable keys and emits one-cycle press, release and repeat pulses.
// PARAMETERS
//  NUM_KEYS        4                  number of tracked keys (1..16)
//  KEY_CODES       {8'h1E,8'h16,8'h5A,8'h29}  packed NUM_KEYS*8; slot i = [8i+7:8i] (default: space, enter, 1, 2)
//  EXT_MASK        4'b0000            bit i = 1: key i requires the E0 prefix
//  TIMEOUT_CYCLES  250_000            max gap between prefix and code byte (5 ms @ 50 MHz)
// PORTS
//  CLOCK_50          in   1           system clock, 50 MHz
//  reset_n           in   1           synchronous active-low reset (driven from KEY[0])
//  received_data     in   8           byte from PS/2 controller
//  received_data_en  in   1           1-cycle strobe: received_data valid
//  flush             in   1           sync clear of held state, no release pulses
//  key_down          out  NUM_KEYS    level: key i currently held
//  key_press         out  NUM_KEYS    1-cycle pulse on first make of key i
//  key_release       out  NUM_KEYS    1-cycle pulse on break of a held key i
//  key_repeat        out  NUM_KEYS    1-cycle pulse on typematic make of an already-held key i
//  any_down          out  1           |key_down
//  last_code         out  8           code byte of last completed make/break event (tracked or not)
//  last_ext          out  1           E0 flag of that event
//  last_break        out  1           1 = last event was a break
// BEHAVIOUR
//  Reset (reset_n == 0 at posedge):
//   - all outputs 0; FSM to IDLE; timeout counter and skip counter 0.
//  FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP. Transitions occur only on strobe, except the timeout.
//   - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; E1 -> SKIP with skip_cnt = 7.
//     FA, AA, EE, FE, 00, FF are ignored (no event).
//     Any other byte -> make(code, ext=0), stay in IDLE.
//   - GOT_E0: F0 -> GOT_E0F0; any other byte -> make(code, ext=1), then IDLE.
//   - GOT_F0: any byte -> break(code, ext=0), then IDLE.
//   - GOT_E0F0: any byte -> break(code, ext=1), then IDLE.
//   - SKIP: each strobe decrements skip_cnt; at 0 -> IDLE. No events are produced (Pause is dropped).
//  Timeout:
//   - Counter clears on every strobe and counts while in any state other than IDLE.
//   - At TIMEOUT_CYCLES-1 the FSM returns to IDLE with no event.
//   - A strobe in the same cycle as the timeout wins: the byte is processed in the current state.
//  Event matching: key i matches when code == KEY_CODES[i] and ext == EXT_MASK[i].
//   All matching slots update, so duplicate codes drive several slots.
//   - make, !key_down[i]: key_down[i] <= 1, key_press[i] pulses.
//   - make, key_down[i]: key_repeat[i] pulses; held state unchanged.
//   - break, key_down[i]: key_down[i] <= 0, key_release[i] pulses.
//   - break, !key_down[i]: no effect.
//   - An unmatched event updates only last_code, last_ext and last_break.
//  Latency: outputs change at the posedge after the strobe edge that completes a sequence (1 cycle).
//   Pulses are exactly 1 cycle wide and never overlap for the same key.
//  flush: key_down <= 0 and no pulses. The FSM is unaffected.
//   If flush and an event coincide, flush wins for key_down and pulses; last_* still update.
//  Reset mid-sequence: the partial sequence is discarded.
//   A break that arrives later for a key that was held before reset is ignored.
// STRUCTURE
//  Shared package/include ps2_codes_pkg:
//   - byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_ACK=FA, PS2_BAT=AA, PS2_ECHO=EE, PS2_RESEND=FE, PS2_ERR0=00, PS2_ERR1=FF.
//   - FSM state encoding.
//   - default key-code constants: space 29, enter 5A, 1 16, 2 1E.
//  Sub-module ps2_seq_decoder: FSM, timeout counter and Pause skip.
//   Outputs evt_valid, evt_break, evt_ext, evt_code[7:0].
//   The top level performs slot matching and drives the held, pulse and last_* registers.
// TESTING
//  1. Bytes 29; F0 29 -> key_press[0] 1 cycle after 29, key_down[0]=1; after the second 29, key_release[0] pulse and key_down[0]=0.
//  2. 5A 5A 5A, then F0 5A -> one key_press[1], two key_repeat[1], one key_release[1].
//  3. EXT_MASK=4'b0001, KEY_CODES[7:0]=8'h75: E0 75 -> key_press[0]; plain 75 -> no pulse, last_code=75, last_ext=0.
//  4. E1 14 77 E1 F0 14 F0 77, then 16 -> no events during Pause; key_press[2] after 16.
//  5. F0, then idle TIMEOUT_CYCLES cycles, then 29 -> treated as make: key_press[0], not a break. Also: strobe exactly on timeout cycle -> byte processed as break.
//  6. Hold 16 and 1E, assert reset_n=0 for 1 cycle -> key_down=0, no pulses; F0 16 afterwards -> no release. Same hold + flush -> key_down=0, no release pulses.

Source files
------------

// File: rtl/ps2_codes_pkg.sv
// PS/2 scan-code byte constants, sequence-decoder state type and default key codes
// shared by the keyboard tracking logic.
package ps2_codes_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam logic [7:0] KEY_SPACE  = 8'h29;
    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_1      = 8'h16;
    localparam logic [7:0] KEY_2      = 8'h1E;

    // Bytes that follow E1 in the Pause make sequence
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0,
        ST_SKIP
    } seq_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_seq_decoder.sv
// Turns the PS/2 byte stream into make/break events, handling E0/F0 prefixes,
// dropping the Pause sequence and abandoning stale prefixes after a timeout.
module ps2_seq_decoder
    import ps2_codes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       evt_valid,
    output logic       evt_break,
    output logic       evt_ext,
    output logic [7:0] evt_code
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    skip_cnt;

    // Events are decoded straight from the completing byte so the tracker
    // registers them on the same edge that samples the strobe.
    always_comb begin
        evt_valid = 1'b0;
        evt_break = 1'b0;
        evt_ext   = 1'b0;
        evt_code  = rx_data;
        if (rx_valid) begin
            case (state)
                ST_IDLE: evt_valid = !(is_ignored(rx_data) || rx_data == PS2_EXT ||
                                       rx_data == PS2_BRK || rx_data == PS2_PAUSE);
                ST_GOT_E0: begin
                    evt_valid = (rx_data != PS2_BRK);
                    evt_ext   = 1'b1;
                end
                ST_GOT_F0: begin
                    evt_valid = 1'b1;
                    evt_break = 1'b1;
                end
                ST_GOT_E0F0: begin
                    evt_valid = 1'b1;
                    evt_break = 1'b1;
                    evt_ext   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            skip_cnt <= '0;
        end else if (rx_valid) begin
            tmo_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (rx_data == PS2_EXT) begin
                        state <= ST_GOT_E0;
                    end else if (rx_data == PS2_BRK) begin
                        state <= ST_GOT_F0;
                    end else if (rx_data == PS2_PAUSE) begin
                        state    <= ST_SKIP;
                        skip_cnt <= PAUSE_TAIL;
                    end
                end
                ST_GOT_E0:   state <= (rx_data == PS2_BRK) ? ST_GOT_E0F0 : ST_IDLE;
                ST_GOT_F0:   state <= ST_IDLE;
                ST_GOT_E0F0: state <= ST_IDLE;
                ST_SKIP: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state <= ST_IDLE;
                end
                default:     state <= ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                state    <= ST_IDLE;
                tmo_cnt  <= '0;
                skip_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks held state of NUM_KEYS configurable PS/2 keys and emits press,
// release and typematic-repeat pulses from the decoded scan-code events.
module ps2_key_tracker
    import ps2_codes_pkg::*;
#(
    parameter int unsigned                NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]      KEY_CODES      = {KEY_2, KEY_1, KEY_ENTER, KEY_SPACE},
    parameter logic [NUM_KEYS-1:0]        EXT_MASK       = '0,
    parameter int unsigned                TIMEOUT_CYCLES = 250_000
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    input  logic                flush,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_down,
    output logic [7:0]          last_code,
    output logic                last_ext,
    output logic                last_break
);

    logic                evt_valid;
    logic                evt_break;
    logic                evt_ext;
    logic [7:0]          evt_code;
    logic [NUM_KEYS-1:0] hit;

    ps2_seq_decoder #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_seq (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .rx_data   (received_data),
        .rx_valid  (received_data_en),
        .evt_valid (evt_valid),
        .evt_break (evt_break),
        .evt_ext   (evt_ext),
        .evt_code  (evt_code)
    );

    // Every slot whose code and E0 requirement match responds, so duplicates are allowed
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            hit[i] = evt_valid && (evt_code == KEY_CODES[8*i +: 8]) && (evt_ext == EXT_MASK[i]);
        end
    end

    assign any_down = |key_down;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            key_down    <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_repeat  <= '0;
            last_code   <= '0;
            last_ext    <= 1'b0;
            last_break  <= 1'b0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            key_repeat  <= '0;
            if (evt_valid) begin
                last_code  <= evt_code;
                last_ext   <= evt_ext;
                last_break <= evt_break;
            end
            if (flush) begin
                key_down <= '0;
            end else if (evt_break) begin
                key_release <= hit & key_down;
                key_down    <= key_down & ~hit;
            end else begin
                key_press   <= hit & ~key_down;
                key_repeat  <= hit & key_down;
                key_down    <= key_down | hit;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed scan-code scenarios plus
// randomized byte streams checked against a prefix-tracking reference model.
module tb_ps2_key_tracker;

    localparam int NK = 6;
    localparam int T  = 16;
    localparam logic [NK*8-1:0] CODES = {8'h5A, 8'h75, 8'h1E, 8'h16, 8'h5A, 8'h29};
    localparam logic [NK-1:0]   EXTM  = 6'b010000;

    // Reference key table, kept separately from the packed parameter above
    logic [7:0] kc [NK] = '{8'h29, 8'h5A, 8'h16, 8'h1E, 8'h75, 8'h5A};
    bit         kx [NK] = '{0, 0, 0, 0, 1, 0};

    logic          CLOCK_50 = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    received_data = 8'h00;
    logic          received_data_en = 1'b0;
    logic          flush = 1'b0;
    logic [NK-1:0] key_down, key_press, key_release, key_repeat;
    logic          any_down;
    logic [7:0]    last_code;
    logic          last_ext, last_break;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_key_tracker #(
        .NUM_KEYS       (NK),
        .KEY_CODES      (CODES),
        .EXT_MASK       (EXTM),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset_n          (reset_n),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .flush            (flush),
        .key_down         (key_down),
        .key_press        (key_press),
        .key_release      (key_release),
        .key_repeat       (key_repeat),
        .any_down         (any_down),
        .last_code        (last_code),
        .last_ext         (last_ext),
        .last_break       (last_break)
    );

    typedef struct packed {
        logic [NK-1:0] down;
        logic          any;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rep;
        logic [7:0]    code;
        logic          ext;
        logic          brk;
    } snap_t;

    snap_t expq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;

    // Reference model: which prefixes have been seen, Pause bytes left to drop,
    // and strobe-free cycles since the last byte.
    bit            m_e0, m_f0;
    int            m_skip, m_gap;
    logic [NK-1:0] m_down;
    logic [7:0]    m_code;
    bit            m_ext, m_brk;

    function automatic bit ignored(input logic [7:0] b);
        return b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    task automatic step(input logic rst_n, input logic en, input logic [7:0] b, input logic fl);
        snap_t e;
        bit ev, brk, ext;
        e = '0;
        ev = 0; brk = 0; ext = 0;
        reset_n = rst_n; received_data_en = en; received_data = b; flush = fl;
        if (!rst_n) begin
            m_e0 = 0; m_f0 = 0; m_skip = 0; m_gap = 0;
            m_down = '0; m_code = 8'h00; m_ext = 0; m_brk = 0;
        end else begin
            if (en) begin
                if ((m_e0 || m_f0 || m_skip > 0) && m_gap >= T) begin
                    m_e0 = 0; m_f0 = 0; m_skip = 0;
                end
                m_gap = 0;
                if (m_skip > 0) begin
                    m_skip--;
                end else if (m_f0) begin
                    ev = 1; brk = 1; ext = m_e0; m_e0 = 0; m_f0 = 0;
                end else if (m_e0) begin
                    if (b == 8'hF0) m_f0 = 1;
                    else begin ev = 1; ext = 1; m_e0 = 0; end
                end else if (b == 8'hE0) m_e0 = 1;
                else if (b == 8'hF0) m_f0 = 1;
                else if (b == 8'hE1) m_skip = 7;
                else if (!ignored(b)) ev = 1;
            end else begin
                m_gap++;
            end
            if (ev) begin m_code = b; m_ext = ext; m_brk = brk; end
            if (fl) m_down = '0;
            else if (ev) begin
                for (int i = 0; i < NK; i++) begin
                    if (kc[i] == b && kx[i] == ext) begin
                        if (brk) begin
                            if (m_down[i]) begin e.rel[i] = 1'b1; m_down[i] = 1'b0; end
                        end else if (m_down[i]) e.rep[i] = 1'b1;
                        else begin e.press[i] = 1'b1; m_down[i] = 1'b1; end
                    end
                end
            end
        end
        e.down = m_down; e.any = |m_down;
        e.code = m_code; e.ext = m_ext; e.brk = m_brk;
        expq.push_back(e);
        @(negedge CLOCK_50);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b1, 1'b1, b, 1'b0);
        repeat (gap) step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: one expected snapshot per clock edge, sampled 1 time unit after it
    initial begin
        snap_t e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_cmp++;
                if (key_down !== e.down || any_down !== e.any) begin
                    n_bad++;
                    $display("FAIL held c%0d: key_down=%b any=%b, expected %b %b", cyc, key_down, any_down, e.down, e.any);
                end
                n_cmp++;
                if (key_press !== e.press || key_release !== e.rel || key_repeat !== e.rep) begin
                    n_bad++;
                    $display("FAIL pulses c%0d: press/rel/rep=%b/%b/%b, expected %b/%b/%b",
                             cyc, key_press, key_release, key_repeat, e.press, e.rel, e.rep);
                end
                n_cmp++;
                if (last_code !== e.code || last_ext !== e.ext || last_break !== e.brk) begin
                    n_bad++;
                    $display("FAIL last c%0d: code=%h ext=%b brk=%b, expected %h %b %b",
                             cyc, last_code, last_ext, last_break, e.code, e.ext, e.brk);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int r, gap;
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);

        send(8'h29, 1); send(8'hF0, 1); send(8'h29, 2);
        send(8'h5A, 1); send(8'h5A, 1); send(8'h5A, 1); send(8'hF0, 0); send(8'h5A, 2);
        send(8'hE0, 1); send(8'h75, 1); send(8'h75, 1); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 2);
        foreach (kc[i]) begin end
        send(8'hE1, 1); send(8'h14, 0); send(8'h77, 1); send(8'hE1, 0);
        send(8'hF0, 1); send(8'h14, 0); send(8'hF0, 1); send(8'h77, 1); send(8'h16, 2);
        send(8'hF0, T); send(8'h29, 2);
        send(8'hF0, T - 1); send(8'h29, 2);
        send(8'hE0, T); send(8'h75, 2);
        send(8'hE1, 1); send(8'h14, T); send(8'h1E, 2);
        send(8'h16, 1); send(8'h1E, 1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        send(8'hF0, 0); send(8'h16, 2);
        send(8'h16, 1); send(8'h1E, 1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        send(8'hF0, 0); send(8'h16, 1); send(8'hF0, 0); send(8'h1E, 1);
        send(8'h29, 1); step(1'b1, 1'b1, 8'h29, 1'b1); step(1'b1, 1'b0, 8'h00, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      b = kc[$urandom_range(0, NK - 1)];
            else if (r < 60) b = 8'hF0;
            else if (r < 70) b = 8'hE0;
            else if (r < 73) b = 8'hE1;
            else if (r < 80) b = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'h00;
            else             b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            if (r < 10)      gap = 0;
            else if (r < 88) gap = $urandom_range(1, 3);
            else             gap = $urandom_range(T - 2, T + 1);
            step(1'b1, 1'b1, b, ($urandom_range(0, 49) == 0));
            repeat (gap) step(1'b1, 1'b0, 8'h00, ($urandom_range(0, 99) == 0));
            if ($urandom_range(0, 299) == 0) step(1'b0, 1'b0, 8'h00, 1'b0);
        end

        repeat (5) @(negedge CLOCK_50);
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d snapshots left, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
